// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit core: datapath widths and the
// memory-access FSM state type.
package cpu10_pkg;

    localparam int unsigned DATA_W      = 10;
    localparam int unsigned MEM_DEPTH   = 256;
    localparam int unsigned RD_W        = 3;
    localparam int unsigned FAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StResp
    } mau_state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Memory-access stage: one load/store at a time, drives the data memory
// port, absorbs its one-cycle read latency and returns a registered response.
module mem_access_unit
    import cpu10_pkg::*;
#(
    parameter int unsigned DataW    = DATA_W,
    parameter int unsigned MemDepth = MEM_DEPTH,
    parameter int unsigned RdW      = RD_W
) (
    input  logic                   CLK,
    input  logic                   RESET,

    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [DataW-1:0]       req_addr_i,
    input  logic [DataW-1:0]       req_wdata_i,
    input  logic [RdW-1:0]         req_rd_i,

    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataW-1:0]       rsp_data_o,
    output logic [RdW-1:0]         rsp_rd_o,
    output logic                   rsp_is_load_o,
    output logic                   rsp_fault_o,

    output logic                   mem_write_o,
    output logic [DataW-1:0]       mem_address_o,
    output logic [DataW-1:0]       mem_write_data_o,
    input  logic [DataW-1:0]       mem_read_data_i,

    output logic [FAULT_CNT_W-1:0] fault_count_o
);

    localparam logic [DataW:0] MemDepthW = (DataW + 1)'(MemDepth);

    mau_state_e             state_q;
    logic [DataW-1:0]       rsp_data_q;
    logic [RdW-1:0]         rsp_rd_q;
    logic                   rsp_is_load_q;
    logic                   rsp_fault_q;
    logic [FAULT_CNT_W-1:0] fault_count_q;

    logic accept;
    logic in_range;

    assign req_ready_o = (state_q == StIdle);
    assign accept      = req_valid_i && req_ready_o;
    assign in_range    = ({1'b0, req_addr_i} < MemDepthW);

    // Outside an in-range accept the memory only ever sees a read of word 0.
    always_comb begin
        mem_write_o      = 1'b0;
        mem_address_o    = '0;
        mem_write_data_o = '0;
        if (accept && in_range) begin
            mem_address_o = req_addr_i;
            if (req_write_i) begin
                mem_write_o      = 1'b1;
                mem_write_data_o = req_wdata_i;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= StIdle;
            rsp_data_q    <= '0;
            rsp_rd_q      <= '0;
            rsp_is_load_q <= 1'b0;
            rsp_fault_q   <= 1'b0;
            fault_count_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        rsp_rd_q      <= req_rd_i;
                        rsp_data_q    <= '0;
                        rsp_fault_q   <= ~in_range;
                        rsp_is_load_q <= ~in_range & ~req_write_i;
                        if (!in_range) begin
                            if (fault_count_q != '1) begin
                                fault_count_q <= fault_count_q + 1'b1;
                            end
                            state_q <= StResp;
                        end else if (req_write_i) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StReadWait;
                        end
                    end
                end
                StReadWait: begin
                    rsp_data_q    <= mem_read_data_i;
                    rsp_is_load_q <= 1'b1;
                    state_q       <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid_o   = (state_q == StResp);
    assign rsp_data_o    = rsp_data_q;
    assign rsp_rd_o      = rsp_rd_q;
    assign rsp_is_load_o = rsp_is_load_q;
    assign rsp_fault_o   = rsp_fault_q;
    assign fault_count_o = fault_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256 x 10-bit registered-read
// data memory model that clears on reset.
module tb_mem_access_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [9:0] req_addr;
    logic [9:0] req_wdata;
    logic [2:0] req_rd;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [9:0] rsp_data;
    logic [2:0] rsp_rd;
    logic       rsp_is_load;
    logic       rsp_fault;
    logic       mem_write;
    logic [9:0] mem_address;
    logic [9:0] mem_write_data;
    logic [9:0] mem_read_data;
    logic [7:0] fault_count;

    int checks   = 0;
    int failures = 0;

    logic [9:0] mem     [256];
    logic [9:0] exp_mem [256];
    logic [9:0] mem_rd_q;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_rd_i         (req_rd),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .rsp_data_o       (rsp_data),
        .rsp_rd_o         (rsp_rd),
        .rsp_is_load_o    (rsp_is_load),
        .rsp_fault_o      (rsp_fault),
        .mem_write_o      (mem_write),
        .mem_address_o    (mem_address),
        .mem_write_data_o (mem_write_data),
        .mem_read_data_i  (mem_read_data),
        .fault_count_o    (fault_count)
    );

    // Data memory: write and registered read on the same edge, cleared on reset.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem_rd_q <= '0;
        end else begin
            if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
            mem_rd_q <= mem[mem_address[7:0]];
        end
    end
    assign mem_read_data = mem_rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic w, input logic [9:0] a, input logic [9:0] d,
                         input logic [2:0] rd);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_rd    = rd;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 0);
        check({tag, "_rsp_rd"}, 32'(rsp_rd), 0);
        check({tag, "_rsp_is_load"}, 32'(rsp_is_load), 0);
        check({tag, "_rsp_fault"}, 32'(rsp_fault), 0);
        check({tag, "_fault_count"}, 32'(fault_count), 0);
        check({tag, "_mem_write"}, 32'(mem_write), 0);
        check({tag, "_mem_address"}, 32'(mem_address), 0);
        check({tag, "_mem_wdata"}, 32'(mem_write_data), 0);
    endtask

    initial begin
        int n_ok;
        RESET     = 1'b1;
        rsp_ready = 1'b1;
        idle();
        #1;
        check_reset_outputs("reset");
        tick();
        RESET = 1'b0;

        // Store 0x2A5 -> 0x013, then load it back into r5.
        drive(1'b1, 10'h013, 10'h2A5, 3'd0);
        @(negedge CLK);
        check("st_mem_write", 32'(mem_write), 1);
        check("st_mem_addr", 32'(mem_address), 'h013);
        check("st_mem_wdata", 32'(mem_write_data), 'h2A5);
        tick();
        idle();
        check("st_mem_write_once", 32'(mem_write), 0);
        check("st_rsp_valid", 32'(rsp_valid), 1);
        check("st_rsp_data", 32'(rsp_data), 0);
        check("st_rsp_is_load", 32'(rsp_is_load), 0);
        check("st_rsp_fault", 32'(rsp_fault), 0);
        tick();
        check("st_back_idle", 32'(req_ready), 1);

        drive(1'b0, 10'h013, 10'h000, 3'd5);
        @(negedge CLK);
        check("ld_mem_write", 32'(mem_write), 0);
        check("ld_mem_addr", 32'(mem_address), 'h013);
        tick();
        idle();
        check("ld_wait_no_rsp", 32'(rsp_valid), 0);
        check("ld_wait_not_ready", 32'(req_ready), 0);
        tick();
        check("ld_rsp_valid", 32'(rsp_valid), 1);
        check("ld_rsp_data", 32'(rsp_data), 'h2A5);
        check("ld_rsp_rd", 32'(rsp_rd), 5);
        check("ld_rsp_is_load", 32'(rsp_is_load), 1);
        check("ld_rsp_fault", 32'(rsp_fault), 0);
        tick();

        // Out-of-range load and store.
        drive(1'b0, 10'h100, 10'h000, 3'd3);
        @(negedge CLK);
        check("fl_ld_mem_write", 32'(mem_write), 0);
        check("fl_ld_mem_addr", 32'(mem_address), 0);
        tick();
        idle();
        check("fl_ld_rsp_valid", 32'(rsp_valid), 1);
        check("fl_ld_rsp_fault", 32'(rsp_fault), 1);
        check("fl_ld_rsp_data", 32'(rsp_data), 0);
        check("fl_ld_rsp_is_load", 32'(rsp_is_load), 1);
        check("fl_ld_rsp_rd", 32'(rsp_rd), 3);
        check("fl_ld_count", 32'(fault_count), 1);
        tick();
        drive(1'b1, 10'h3FF, 10'h155, 3'd0);
        @(negedge CLK);
        check("fl_st_mem_write", 32'(mem_write), 0);
        check("fl_st_mem_addr", 32'(mem_address), 0);
        check("fl_st_mem_wdata", 32'(mem_write_data), 0);
        tick();
        idle();
        check("fl_st_rsp_fault", 32'(rsp_fault), 1);
        check("fl_st_rsp_data", 32'(rsp_data), 0);
        check("fl_st_rsp_is_load", 32'(rsp_is_load), 0);
        check("fl_st_count", 32'(fault_count), 2);
        tick();

        // Backpressure: load held in RESP for 4 cycles with a store waiting.
        rsp_ready = 1'b0;
        drive(1'b0, 10'h013, 10'h000, 3'd6);
        tick();
        drive(1'b1, 10'h022, 10'h111, 3'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check("bp_rsp_valid", 32'(rsp_valid), 1);
            check("bp_rsp_data", 32'(rsp_data), 'h2A5);
            check("bp_rsp_rd", 32'(rsp_rd), 6);
            check("bp_rsp_is_load", 32'(rsp_is_load), 1);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_mem_write", 32'(mem_write), 0);
            check("bp_mem_addr", 32'(mem_address), 0);
            if (c < 3) tick();
        end
        tick();
        rsp_ready = 1'b1;
        idle();
        check("bp_release_still_valid", 32'(rsp_valid), 1);
        tick();
        check("bp_idle_ready", 32'(req_ready), 1);
        check("bp_idle_valid", 32'(rsp_valid), 0);

        // Reset while in READ_WAIT.
        drive(1'b0, 10'h013, 10'h000, 3'd7);
        tick();
        check("rst_in_wait", 32'(req_ready), 0);
        req_valid = 1'b0;
        RESET     = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        RESET = 1'b0;
        drive(1'b0, 10'h013, 10'h000, 3'd2);
        tick();
        idle();
        tick();
        check("rst_ld_valid", 32'(rsp_valid), 1);
        check("rst_ld_data_cleared", 32'(rsp_data), 'h000);
        tick();

        // 300 faults saturate the counter at 255.
        for (int i = 0; i < 300; i++) begin
            drive(i[0], 10'h200 + 10'(i), 10'h0AA, 3'd1);
            tick();
            idle();
            tick();
        end
        check("sat_count", 32'(fault_count), 255);
        drive(1'b1, 10'h055, 10'h0AB, 3'd0);
        @(negedge CLK);
        check("sat_st_mem_write", 32'(mem_write), 1);
        check("sat_st_mem_addr", 32'(mem_address), 'h055);
        tick();
        idle();
        check("sat_st_rsp_fault", 32'(rsp_fault), 0);
        check("sat_count_hold", 32'(fault_count), 255);
        tick();

        // Back-to-back stores over the whole memory, then reload everything.
        n_ok = 0;
        for (int i = 0; i < 256; i++) begin
            exp_mem[i] = 10'($urandom_range(0, 1023));
            drive(1'b1, 10'(i), exp_mem[i], 3'd0);
            if (req_ready && mem_write) n_ok++;
            tick();
            if (!req_ready && rsp_valid && !mem_write) n_ok++;
            tick();
        end
        check("store_cadence", 32'(n_ok), 512);
        n_ok = 0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 10'(i), 10'h000, 3'(i));
            if (req_ready) n_ok++;
            tick();
            if (!rsp_valid && !req_ready) n_ok++;
            tick();
            if (rsp_valid && rsp_is_load && rsp_rd == 3'(i)) n_ok++;
            check("sweep_ld_data", 32'(rsp_data), 32'(exp_mem[i]));
            tick();
        end
        idle();
        check("load_cadence", 32'(n_ok), 768);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the 10-bit core. Sits between the execute stage and the 256 x 10-bit data memory. Accepts one load/store request at a time over a valid/ready handshake, drives the memory's write-enable, address and write-data inputs, and absorbs the memory's one-cycle registered read latency. Returns a registered response (load data, destination register, fault flag) to writeback.

## Interface
Parameters:
- DATA_W, 10, data and address width
- MEM_DEPTH, 256, number of implemented words; addresses at or above this fault
- RD_W, 3, destination-register index width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  reset, asynchronous, active-high
- req_valid  in  1  execute stage presents a request
- req_ready  out  1  unit can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  DATA_W  word address
- req_wdata  in  DATA_W  store data
- req_rd  in  RD_W  load destination register, echoed on response
- rsp_valid  out  1  response available
- rsp_ready  in  1  writeback accepts response
- rsp_data  out  DATA_W  load data; 0 for stores and faults
- rsp_rd  out  RD_W  echoed req_rd
- rsp_is_load  out  1  response belongs to a load
- rsp_fault  out  1  address out of range; no memory access performed
- mem_write  out  1  to memory MEM_WRITE
- mem_address  out  DATA_W  to memory ADDRESS
- mem_write_data  out  DATA_W  to memory WRITE_DATA
- mem_read_data  in  DATA_W  from memory READ_DATA (valid one edge after a read address)
- fault_count  out  8  saturating count of faulted requests

## Operation
- States: IDLE, READ_WAIT, RESP.
- Accept = req_valid && req_ready, in IDLE only.
- In-range: req_addr < MEM_DEPTH, i.e. req_addr[9:8] == 0.
- IDLE, accept, in-range store: mem_write = 1, mem_address = req_addr, mem_write_data = req_wdata, combinationally in the accept cycle. Load response registers with rsp_data = 0, rsp_is_load = 0, rsp_fault = 0. Next state RESP.
- IDLE, accept, in-range load: mem_write = 0, mem_address = req_addr. Latch req_rd. Next state READ_WAIT.
- IDLE, accept, out-of-range (load or store): mem_write = 0, mem_address = 0. Response has rsp_fault = 1, rsp_data = 0, rsp_is_load = ~req_write. fault_count increments, saturating at 255. Next state RESP.
- READ_WAIT: capture mem_read_data into rsp_data, set rsp_is_load = 1. Next state RESP unconditionally.
- RESP: rsp_valid = 1. All rsp_* signals hold stable until rsp_ready. On rsp_ready, go to IDLE.
- When not accepting, mem_write = 0, mem_address = 0, mem_write_data = 0. The memory sees only harmless reads of word 0.
- mem_write is never asserted outside an accept cycle. It is never asserted for a faulting address.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_data 0, rsp_rd 0, rsp_is_load 0, rsp_fault 0, fault_count 0, mem_* outputs 0.
- Store accepted at edge T: memory written at edge T, rsp_valid high from T+1.
- Load accepted at edge T: memory registers data at T, unit captures at T+1, rsp_valid high from T+2.
- Fault accepted at T: rsp_valid high from T+1.
- Best-case throughput with rsp_ready held high: one store per 2 cycles, one load per 3 cycles.
- A load after a store to the same address always returns the new data, because the store completes before the next request can be accepted.
- Backpressure: while rsp_ready is low in RESP, req_ready stays 0 and no memory access occurs.
- Reset mid-operation (any state): returns asynchronously to IDLE and the pending response is dropped. The memory clears its contents on reset, so an in-flight store is lost by design.
- fault_count at 255 stays at 255.

## Structure
- Shared package cpu10_pkg holds DATA_W = 10, MEM_DEPTH = 256, RD_W = 3, and the state enum (IDLE, READ_WAIT, RESP) for waveform-readable debug.
- Single module with no sub-modules. The saturating fault counter and the FSM are inline. The top level instantiates this unit next to the data memory and wires mem_* port-to-port.

## Test plan
- Reset, then store 0x2A5 to address 0x013, then load 0x013 with req_rd = 5. Expect mem_write high for exactly one cycle, load response at accept+2 with rsp_data = 0x2A5, rsp_rd = 5, rsp_is_load = 1.
- Load address 0x100, then store to 0x3FF. Expect rsp_fault = 1 and rsp_data = 0 for both, mem_write never high, fault_count = 2.
- Load 0x013 with rsp_ready held low for 4 cycles. Expect rsp_* stable and req_ready = 0 throughout, then return to IDLE one cycle after rsp_ready rises.
- Assert RESET during READ_WAIT. Expect all outputs at reset values immediately. After release, a load of 0x013 returns 0x000.
- Issue 300 out-of-range requests. Expect fault_count = 255, then a valid store still succeeds.
- Back-to-back stores to 0x000..0x0FF with random data, then loads of all 256 addresses. Expect every load to return its stored value, with a 2-cycle and 3-cycle accept cadence respectively.
